// File: rtl/serial_alu_defs.sv
// Shared definitions for the bit-serial ALU datapath.
// State encodings and the default operand width.
package serial_alu_defs;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial bit step.
// Purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial signed adder/subtractor, LSB first, one bit per clock.
// Reports the MSB carry pair and signed overflow for the flag logic.
module serial_addsub
    import serial_alu_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             msb_cin,
    output logic             cout,
    output logic             v
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] br;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last;

    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign accept = start && !busy;
    assign last   = (cnt == LAST);
    assign v      = msb_cin ^ cout;

    full_adder u_fa (
        .a    (ar[0]),
        .b    (br[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last) state_nx = ST_DONE;
            ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Explicit wrap keeps non-power-of-2 widths from overrunning cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar      <= '0;
            br      <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            msb_cin <= 1'b0;
            cout    <= 1'b0;
        end else if (accept) begin
            ar    <= a;
            br    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (busy) begin
            ar    <= ar >> 1;
            br    <= br >> 1;
            sum   <= {fa_s, sum[WIDTH-1:1]};
            carry <= fa_co;
            if (last) begin
                cnt     <= '0;
                msb_cin <= carry;
                cout    <= fa_co;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8).
// Directed corner cases plus random ops against an arithmetic model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         msb_cin;
    logic         cout;
    logic         v;

    int nvec = 0;
    int nerr = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .msb_cin (msb_cin),
        .cout    (cout),
        .v       (v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int k);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i;
                break;
            end
        end
        if (k == 0) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_res(input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic ts, input string tag);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        logic         exp_mc;
        logic [W-1:0] ref_s;
        bb     = ts ? ~tb : tb;
        full   = {1'b0, ta} + {1'b0, bb} + (W+1)'(ts);
        low    = {1'b0, ta[W-2:0]} + {1'b0, bb[W-2:0]} + W'(ts);
        exp_mc = low[W-1];
        ref_s  = ts ? ta - tb : ta + tb;
        chk({tag, "_sum"}, sum, ref_s);
        chk({tag, "_cout"}, cout, full[W]);
        chk({tag, "_mcin"}, msb_cin, exp_mc);
        chk({tag, "_v"}, v, exp_mc ^ full[W]);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input string tag);
        int k;
        @(negedge clk);
        a = ta;
        b = tb;
        sub = ts;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_done(tag, k);
        chk({tag, "_lat"}, k, W);
        check_res(ta, tb, ts, tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int k;
        int seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        #2 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_v", v, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(8'h7F, 8'h01, 1'b0, "ovf_pos");
        chk("ovf_pos_k", {sum, msb_cin, cout, v}, {8'h80, 3'b101});
        run_op(8'hFF, 8'h01, 1'b0, "wrap");
        chk("wrap_k", {sum, msb_cin, cout, v}, {8'h00, 3'b110});
        run_op(8'h80, 8'h80, 1'b0, "ovf_neg");
        chk("ovf_neg_k", {sum, msb_cin, cout, v}, {8'h00, 3'b011});

        // Back-to-back with start held high through DONE.
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h80;
        b = 8'h01;
        sub = 1'b1;
        wait_done("b2b1", k);
        chk("b2b1_lat", k, W);
        chk("b2b1_k", {sum, msb_cin, cout, v}, {8'h03, 3'b000});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_nogap", busy, 1);
        chk("b2b_pulse", done, 0);
        wait_done("b2b2", k);
        chk("b2b2_lat", k, W);
        chk("b2b2_k", {sum, msb_cin, cout, v}, {8'h7F, 3'b011});
        check_res(8'h80, 8'h01, 1'b1, "b2b2");

        // Start during RUN is ignored.
        @(negedge clk);
        a = 8'h05;
        b = 8'h05;
        sub = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'hAA;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign", k);
        chk("ign_lat", k + 3, W);
        chk("ign_k", {sum, msb_cin, cout, v}, {8'h00, 3'b110});
        @(posedge clk);
        #1;
        chk("ign_idle", busy, 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 8'h7F;
        b = 8'h01;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_sum", sum, 0);
        chk("mid_v", v, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("mid_nodone", seen, 0);
        run_op(8'h01, 8'h01, 1'b0, "post");
        chk("post_k", sum, 8'h02);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
